// File: rtl/shift_sub_divide.sv
// shift_sub_divide: unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        request; accepted only while idle
//   dividend     n-bit unsigned dividend, captured on the accepting edge
//   divisor      n-bit unsigned divisor, captured on the accepting edge
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   busy         high while a division is iterating
//   done         one-cycle pulse in the cycle the results become valid
//   div_by_zero  set with done when the captured divisor was zero;
//                held until the next accepted start
//
// A nonzero divisor produces done exactly n cycles after the accepting edge.
// A zero divisor never enters RUN; results appear one cycle after acceptance.
module shift_sub_divide #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nx;
  logic [n-1:0]   a;      // partial remainder; always < M, so n bits suffice
  logic [n-1:0]   q;
  logic [n:0]     m;
  logic [CW-1:0]  count;

  logic [n:0]     a_sh;   // A after the {A,Q} shift: n+1 bits wide
  logic [n:0]     t;
  logic [n-1:0]   a_nx;
  logic [n-1:0]   q_nx;
  logic           last;
  logic           div_zero_in;

  always_comb begin
    a_sh        = {a, q[n-1]};
    t           = a_sh - m;
    // Restoring step: keep the difference only when it did not go negative.
    a_nx        = t[n] ? a_sh[n-1:0] : t[n-1:0];
    q_nx        = {q[n-2:0], ~t[n]};
    last        = (count == CW'(n - 1));
    div_zero_in = (divisor == '0);

    state_nx = state;
    case (state)
      IDLE: if (start && !div_zero_in) state_nx = RUN;
      RUN:  if (last)                  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      a           <= '0;
      q           <= '0;
      m           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= div_zero_in;
            if (div_zero_in) begin
              quotient  <= '1;
              remainder <= dividend;
              done      <= 1'b1;
            end else begin
              a     <= '0;
              q     <= dividend;
              m     <= {1'b0, divisor};
              count <= '0;
            end
          end
        end
        RUN: begin
          a     <= a_nx;
          q     <= q_nx;
          count <= count + 1'b1;
          if (last) begin
            quotient  <= q_nx;
            remainder <= a_nx;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divide.sv
// Self-checking bench for shift_sub_divide (n = 32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_shift_sub_divide;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  shift_sub_divide #(.n(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] dvd;
    logic [N-1:0] dvs;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: present a request, let the next rising edge
  // accept it, then scramble the operand inputs to prove they are not reused.
  task automatic launch(input logic [N-1:0] dvd, input logic [N-1:0] dvs);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // lat counts rising edges after the accepting edge; bounded wait.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                           input logic [N-1:0] eq, input logic [N-1:0] er, input logic ez);
    int lat;
    launch(dvd, dvs);
    chk({tag, ".busy_start"}, N'(busy), N'(ez ? 1'b0 : 1'b1));
    wait_done(0, lat);
    chk({tag, ".latency"}, N'(lat), ez ? N'(0) : N'(N));
    chk({tag, ".quotient"}, quotient, eq);
    chk({tag, ".remainder"}, remainder, er);
    chk({tag, ".div_by_zero"}, N'(div_by_zero), N'(ez));
    @(negedge clk);
    chk({tag, ".done_pulse"}, N'(done), N'(0));
    chk({tag, ".busy_end"}, N'(busy), N'(0));
    chk({tag, ".hold_q"}, quotient, eq);
    chk({tag, ".hold_dbz"}, N'(div_by_zero), N'(ez));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int ndone;
    logic [N-1:0] rd, rs;

    vecs[0] = '{dvd: 32'd100,        dvs: 32'd7,          q: 32'd14,         r: 32'd2,          z: 1'b0};
    vecs[1] = '{dvd: 32'hFFFF_FFFF,  dvs: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          z: 1'b0};
    vecs[2] = '{dvd: 32'hFFFF_FFFF,  dvs: 32'h8000_0000,  q: 32'd1,          r: 32'h7FFF_FFFF,  z: 1'b0};
    vecs[3] = '{dvd: 32'd5,          dvs: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd5,          z: 1'b1};
    vecs[4] = '{dvd: 32'd3,          dvs: 32'd10,         q: 32'd0,          r: 32'd3,          z: 1'b0};
    vecs[5] = '{dvd: 32'd0,          dvs: 32'd9,          q: 32'd0,          r: 32'd0,          z: 1'b0};
    vecs[6] = '{dvd: 32'd7,          dvs: 32'd7,          q: 32'd1,          r: 32'd0,          z: 1'b0};
    vecs[7] = '{dvd: 32'hFFFF_FFFF,  dvs: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,          z: 1'b0};
    vecs[8] = '{dvd: 32'd0,          dvs: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd0,          z: 1'b1};

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst.quotient", quotient, '0);
    chk("rst.remainder", remainder, '0);
    chk("rst.busy", N'(busy), N'(0));
    chk("rst.done", N'(done), N'(0));
    chk("rst.dbz", N'(div_by_zero), N'(0));

    // Reset wins over a simultaneous start, for both divisor kinds.
    reset = 1'b1; start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_vs_start.busy", N'(busy), N'(0));
    reset = 1'b1; start = 1'b1; dividend = 32'd5; divisor = 32'd0;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_vs_start0.done", N'(done), N'(0));
    chk("rst_vs_start0.quotient", quotient, '0);

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].z);

    // Randomised operands against plain integer division.
    for (int i = 0; i < 24; i++) begin
      rd = $urandom;
      case (i % 4)
        0: rs = $urandom;
        1: rs = $urandom_range(1, 255);
        2: rs = (i % 8 == 2) ? 32'd0 : (rd | 32'h1) + 32'd1 + $urandom_range(0, 1000);
        default: rs = {1'b1, 31'($urandom)};
      endcase
      if (rs == 0)
        run_check($sformatf("rnd%0d", i), rd, rs, '1, rd, 1'b1);
      else
        run_check($sformatf("rnd%0d", i), rd, rs, rd / rs, rd % rs, 1'b0);
    end

    // Start in the done cycle is accepted; old results hold until completion.
    launch(32'd3, 32'd10);
    wait_done(0, lat);
    chk("b2b.lat1", N'(lat), N'(N));
    chk("b2b.q1", quotient, 32'd0);
    chk("b2b.r1", remainder, 32'd3);
    launch(32'd50, 32'd5);
    chk("b2b.busy", N'(busy), N'(1));
    chk("b2b.r_hold", remainder, 32'd3);
    wait_done(0, lat);
    chk("b2b.lat2", N'(lat), N'(N));
    chk("b2b.q2", quotient, 32'd10);
    chk("b2b.r2", remainder, 32'd0);
    @(negedge clk);

    // Start while running is ignored.
    launch(32'd100, 32'd7);
    lat = 0;
    repeat (9) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    lat++;
    start = 1'b0;
    wait_done(lat, lat);
    chk("ign.lat", N'(lat), N'(N));
    chk("ign.q", quotient, 32'd14);
    chk("ign.r", remainder, 32'd2);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("ign.extra_done", N'(ndone), N'(0));
    chk("ign.busy", N'(busy), N'(0));

    // Reset mid-run aborts with no done pulse.
    launch(32'd100, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.q", quotient, '0);
    chk("abort.r", remainder, '0);
    chk("abort.busy", N'(busy), N'(0));
    chk("abort.done", N'(done), N'(0));
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort.no_done", N'(ndone), N'(0));
    run_check("abort.after", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // start held high restarts immediately in each done cycle.
    start = 1'b1; dividend = 32'd20; divisor = 32'd6;
    @(negedge clk);
    wait_done(0, lat);
    chk("hold.lat1", N'(lat), N'(N));
    chk("hold.q1", quotient, 32'd3);
    chk("hold.r1", remainder, 32'd2);
    dividend = 32'd50; divisor = 32'd7;
    @(negedge clk);
    chk("hold.busy", N'(busy), N'(1));
    wait_done(1, lat);
    start = 1'b0;
    chk("hold.lat2", N'(lat), N'(N + 1));
    chk("hold.q2", quotient, 32'd7);
    chk("hold.r2", remainder, 32'd1);
    @(negedge clk);
    chk("hold.done_end", N'(done), N'(0));
    @(negedge clk);
    chk("hold.busy_end", N'(busy), N'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sub_divide.md
SHIFT_SUB_DIVIDE -- requirements
Module: shift_sub_divide

Interface
REQ-001 Parameter n, default 32, operand/result width in bits.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request: sampled high in IDLE -> capture operands, begin division.
REQ-005 dividend  input  n  unsigned dividend, sampled only on accepting edge.
REQ-006 divisor  input  n  unsigned divisor, sampled only on accepting edge.
REQ-007 quotient  output  n  registered unsigned quotient, held until next completion.
REQ-008 remainder  output  n  registered unsigned remainder, held until next completion.
REQ-009 busy  output  1  high while a division is in progress (state RUN).
REQ-010 done  output  1  one-cycle pulse, high the cycle results become valid.
REQ-011 div_by_zero  output  1  set with done when captured divisor was 0; held until next accepted start.

Function
REQ-012 States SHALL be exactly IDLE and RUN; there is no separate DONE state.
REQ-013 IDLE: start=1 -> state RUN, busy=1, done=0, div_by_zero=0; A(n+1 bits)=0, Q=dividend, M={1'b0,divisor}, count=0.
REQ-014 IDLE: start=1 with divisor=0 -> no RUN; next edge writes quotient=all ones, remainder=dividend, div_by_zero=1, done=1; state stays IDLE.
REQ-015 RUN, each edge: {A,Q} shifted left 1; T = A - M (n+1 bits); T MSB=0 -> A=T, Q[0]=1; else A unchanged (restoring), Q[0]=0; count+1.
REQ-016 RUN edge processing count=n-1: quotient=final Q, remainder=final A[n-1:0], done=1, busy=0, state IDLE.
REQ-017 Latency: nonzero divisor -> done high exactly n clock cycles after the accepting edge (n=32 -> 32 cycles).
REQ-018 done SHALL be 0 in every cycle other than the completion cycle.
REQ-019 start while RUN SHALL be ignored; operands and progress unaffected.
REQ-020 start high in the done cycle SHALL be accepted (state already IDLE); quotient/remainder keep prior values until the new completion.
REQ-021 Holding start high continuously SHALL restart a new division each time IDLE is reached.
REQ-022 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every nonzero divisor, including dividend < divisor (quotient 0, remainder dividend) and dividend = 0.
REQ-023 Internal subtraction SHALL use n+1 bits so divisor with MSB set never overflows.
REQ-024 quotient, remainder, busy, done, div_by_zero SHALL be registered outputs, no combinational path from inputs.

Reset
REQ-025 reset=1 on an edge: state IDLE; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0; A, Q, M, count cleared.
REQ-026 reset SHALL override start on the same edge; start is not accepted.
REQ-027 reset during RUN SHALL abort the division with no done pulse and no result update beyond the reset values.
REQ-028 No behaviour depends on initial register values; the first operation is defined only after one reset edge.

Verification
REQ-029 reset; start, dividend=100, divisor=7 -> busy 32 cycles, done pulse at cycle 32, quotient=14, remainder=2.
REQ-030 dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; dividend=0xFFFFFFFF, divisor=0x80000000 -> quotient=1, remainder=0x7FFFFFFF.
REQ-031 dividend=5, divisor=0 -> one cycle later done=1, div_by_zero=1, quotient=0xFFFFFFFF, remainder=5, busy never high.
REQ-032 dividend=3, divisor=10 -> quotient=0, remainder=3; then start asserted in done cycle with 50/5 -> second done 32 cycles later, quotient=10, remainder=0.
REQ-033 start 100/7, start pulsed again with 9/3 at cycle 10 -> ignored, single done at cycle 32 with quotient=14, remainder=2.
REQ-034 start 100/7, reset at cycle 15 -> no done, all outputs 0, busy 0; new start 9/3 -> quotient=3, remainder=0 after 32 cycles.
